// File: rtl/median_result_buffer.sv
// median_result_buffer: packs 1-bit median results into a frame buffer of 8-bit words, then streams the frame out.
// Latency: filterDone sampled at edge M -> first byteValid after edge M+3, then one byte per cycle.
// Backpressure: byteOut/byteValid/byteLast hold while byteReady is low; a skid register absorbs the in-flight read.
//
// Optional feature macro: RESULT_BUF_CLEAR_EN. When defined, the whole buffer is zeroed before each
// capture so unwritten border pixels read 0. When undefined the clear is a single idle cycle and words
// the filter never touches keep their previous-frame contents.
//
// Ports:
//   clk, reset (async, active-high)     clock and reset
//   start                               begin a new frame (only honoured in IDLE)
//   writeEnable, xMedianAddress,
//   yMedianAddress, dataIn              median result write (x, y, bit)
//   filterDone                          end of capture
//   byteReady / byteOut, byteValid,
//   byteLast                            output byte stream, LSB = lowest pixel
//   bufferReady, busy                   status
//   orderError, rangeError              sticky error flags, cleared on start
module median_result_buffer #(
   parameter int IMAGE_WIDTH  = 240,
   parameter int IMAGE_HEIGHT = 180
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       writeEnable,
   input  logic [7:0] xMedianAddress,
   input  logic [7:0] yMedianAddress,
   input  logic       dataIn,
   input  logic       filterDone,
   input  logic       byteReady,
   output logic       bufferReady,
   output logic       busy,
   output logic [7:0] byteOut,
   output logic       byteValid,
   output logic       byteLast,
   output logic       orderError,
   output logic       rangeError
);

   localparam int PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int WORDS  = (PIXELS + 7) / 8;
   localparam int AW     = $clog2(WORDS);
   localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);
   localparam logic [15:0]   WIDTH16  = 16'(IMAGE_WIDTH);
   localparam logic [15:0]   HEIGHT16 = 16'(IMAGE_HEIGHT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_CAPTURE,
      ST_FLUSH,
      ST_DRAIN
   } state_t;

   state_t state_q, state_d;

   // capture accumulator
   logic [AW-1:0] pend_idx_q, pend_idx_d;
   logic [7:0]    pend_word_q, pend_word_d;
   logic          pend_vld_q, pend_vld_d;
   logic          order_err_q, order_err_d;
   logic          range_err_q, range_err_d;

   // drain read side
   logic [AW-1:0] rd_idx_q, rd_idx_d;
   logic          rd_done_q, rd_done_d;
   logic          rd_inflight_q, rd_inflight_d;
   logic          rd_last_q, rd_last_d;

   // output head register and skid register
   logic          out_vld_q, out_vld_d;
   logic [7:0]    out_dat_q, out_dat_d;
   logic          out_last_q, out_last_d;
   logic          skid_vld_q, skid_vld_d;
   logic [7:0]    skid_dat_q, skid_dat_d;
   logic          skid_last_q, skid_last_d;

`ifdef RESULT_BUF_CLEAR_EN
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

   // frame buffer
   logic [7:0]    mem [0:WORDS-1];
   logic [7:0]    rd_dat_q;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [7:0]    mem_wdat;
   logic          mem_re;

   // write address decode
   logic [15:0]   x_ext, y_ext, lin_addr;
   logic [AW-1:0] wr_idx;
   logic [2:0]    wr_bit;
   logic          in_range;

   assign x_ext    = {8'd0, xMedianAddress};
   assign y_ext    = {8'd0, yMedianAddress};
   assign lin_addr = y_ext * WIDTH16 + x_ext;
   assign wr_idx   = lin_addr[AW+2:3];
   assign wr_bit   = lin_addr[2:0];
   assign in_range = (x_ext < WIDTH16) && (y_ext < HEIGHT16);

   logic pop;
   assign pop = out_vld_q && byteReady;

   // working copies of the head/skid pair while the drain step is evaluated
   logic       h_vld, h_last, s_vld, s_last;
   logic [7:0] h_dat, s_dat;

   always_comb begin
      state_d       = state_q;
      pend_idx_d    = pend_idx_q;
      pend_word_d   = pend_word_q;
      pend_vld_d    = pend_vld_q;
      order_err_d   = order_err_q;
      range_err_d   = range_err_q;
      rd_idx_d      = rd_idx_q;
      rd_done_d     = rd_done_q;
      rd_inflight_d = 1'b0;
      rd_last_d     = rd_last_q;
`ifdef RESULT_BUF_CLEAR_EN
      clr_cnt_d     = clr_cnt_q;
`endif
      mem_we        = 1'b0;
      mem_waddr     = pend_idx_q;
      mem_wdat      = pend_word_q;
      mem_re        = 1'b0;
      h_vld         = out_vld_q;
      h_dat         = out_dat_q;
      h_last        = out_last_q;
      s_vld         = skid_vld_q;
      s_dat         = skid_dat_q;
      s_last        = skid_last_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_CLEAR;
               order_err_d = 1'b0;
               range_err_d = 1'b0;
               pend_vld_d  = 1'b0;
               rd_idx_d    = '0;
               rd_done_d   = 1'b0;
`ifdef RESULT_BUF_CLEAR_EN
               clr_cnt_d   = '0;
`endif
            end
         end

         ST_CLEAR: begin
`ifdef RESULT_BUF_CLEAR_EN
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdat  = 8'h00;
            if (clr_cnt_q == LAST_IDX) begin
               state_d = ST_CAPTURE;
            end else begin
               clr_cnt_d = clr_cnt_q + AW'(1);
            end
`else
            state_d = ST_CAPTURE;
`endif
         end

         ST_CAPTURE: begin
            if (writeEnable) begin
               // range is judged before order so a wild address never commits a word
               if (!in_range) begin
                  range_err_d = 1'b1;
               end else if (pend_vld_q && (wr_idx == pend_idx_q)) begin
                  pend_word_d[wr_bit] = dataIn;
               end else if (!pend_vld_q || (wr_idx > pend_idx_q)) begin
                  // moving to a new word: retire the old one, start fresh from zero
                  mem_we      = pend_vld_q;
                  pend_word_d = {7'd0, dataIn} << wr_bit;
                  pend_idx_d  = wr_idx;
                  pend_vld_d  = 1'b1;
               end else begin
                  order_err_d = 1'b1;
               end
            end
            if (filterDone) begin
               state_d = ST_FLUSH;
            end
         end

         ST_FLUSH: begin
            mem_we     = pend_vld_q;
            pend_vld_d = 1'b0;
            state_d    = ST_DRAIN;
         end

         ST_DRAIN: begin
            if (pop) begin
               h_vld  = s_vld;
               h_dat  = s_dat;
               h_last = s_last;
               s_vld  = 1'b0;
            end
            if (rd_inflight_q) begin
               if (!h_vld) begin
                  h_vld  = 1'b1;
                  h_dat  = rd_dat_q;
                  h_last = rd_last_q;
               end else begin
                  s_vld  = 1'b1;
                  s_dat  = rd_dat_q;
                  s_last = rd_last_q;
               end
            end
            // issue only while a slot is guaranteed for the data returning next cycle
            if (!rd_done_q && !s_vld) begin
               mem_re        = 1'b1;
               rd_inflight_d = 1'b1;
               rd_last_d     = (rd_idx_q == LAST_IDX);
               if (rd_idx_q == LAST_IDX) begin
                  rd_done_d = 1'b1;
               end else begin
                  rd_idx_d = rd_idx_q + AW'(1);
               end
            end
            if (pop && out_last_q) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      out_vld_d   = h_vld;
      out_dat_d   = h_dat;
      out_last_d  = h_last;
      skid_vld_d  = s_vld;
      skid_dat_d  = s_dat;
      skid_last_d = s_last;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pend_idx_q    <= '0;
         pend_word_q   <= 8'h00;
         pend_vld_q    <= 1'b0;
         order_err_q   <= 1'b0;
         range_err_q   <= 1'b0;
         rd_idx_q      <= '0;
         rd_done_q     <= 1'b0;
         rd_inflight_q <= 1'b0;
         rd_last_q     <= 1'b0;
         out_vld_q     <= 1'b0;
         out_dat_q     <= 8'h00;
         out_last_q    <= 1'b0;
         skid_vld_q    <= 1'b0;
         skid_dat_q    <= 8'h00;
         skid_last_q   <= 1'b0;
`ifdef RESULT_BUF_CLEAR_EN
         clr_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         pend_idx_q    <= pend_idx_d;
         pend_word_q   <= pend_word_d;
         pend_vld_q    <= pend_vld_d;
         order_err_q   <= order_err_d;
         range_err_q   <= range_err_d;
         rd_idx_q      <= rd_idx_d;
         rd_done_q     <= rd_done_d;
         rd_inflight_q <= rd_inflight_d;
         rd_last_q     <= rd_last_d;
         out_vld_q     <= out_vld_d;
         out_dat_q     <= out_dat_d;
         out_last_q    <= out_last_d;
         skid_vld_q    <= skid_vld_d;
         skid_dat_q    <= skid_dat_d;
         skid_last_q   <= skid_last_d;
`ifdef RESULT_BUF_CLEAR_EN
         clr_cnt_q     <= clr_cnt_d;
`endif
      end
   end

   // RAM contents and its read register are deliberately not reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdat;
      end
      if (mem_re) begin
         rd_dat_q <= mem[rd_idx_q];
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign bufferReady = (state_q == ST_CAPTURE);
   assign byteOut     = out_dat_q;
   assign byteValid   = out_vld_q;
   assign byteLast    = out_last_q;
   assign orderError  = order_err_q;
   assign rangeError  = range_err_q;

endmodule

// File: tb/tb_median_result_buffer.sv
module tb_median_result_buffer;

   localparam int W     = 240;
   localparam int H     = 180;
   localparam int WORDS = 5400;
`ifdef RESULT_BUF_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       writeEnable = 1'b0;
   logic [7:0] xMedianAddress = 8'd0;
   logic [7:0] yMedianAddress = 8'd0;
   logic       dataIn = 1'b0;
   logic       filterDone = 1'b0;
   logic       byteReady = 1'b0;
   logic       bufferReady, busy, byteValid, byteLast, orderError, rangeError;
   logic [7:0] byteOut;

   median_result_buffer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
      .clk(clk), .reset(reset), .start(start), .writeEnable(writeEnable),
      .xMedianAddress(xMedianAddress), .yMedianAddress(yMedianAddress),
      .dataIn(dataIn), .filterDone(filterDone), .byteReady(byteReady),
      .bufferReady(bufferReady), .busy(busy), .byteOut(byteOut),
      .byteValid(byteValid), .byteLast(byteLast),
      .orderError(orderError), .rangeError(rangeError)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference image of the buffer plus the reference accumulator position
   logic [7:0] model_mem [WORDS];
   int         m_pidx;
   bit         m_pvld;

   logic [7:0] exp_q [$];
   logic [7:0] rx [WORDS];
   int         rx_cnt;

   typedef struct {
      int   x;
      int   y;
      logic d;
      logic exp_oerr;
      logic exp_rerr;
   } wr_vec_t;
   wr_vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_start();
      m_pvld = 1'b0;
      if (CLEAR_EN) begin
         for (int i = 0; i < WORDS; i++) model_mem[i] = 8'h00;
      end
   endtask

   task automatic model_write(input int x, input int y, input logic d);
      int l, w, b;
      if (x < W && y < H) begin
         l = y * W + x;
         w = l / 8;
         b = l % 8;
         if (m_pvld && w == m_pidx) begin
            model_mem[w][b] = d;
         end else if (!m_pvld || w > m_pidx) begin
            model_mem[w]    = 8'h00;
            model_mem[w][b] = d;
            m_pidx = w;
            m_pvld = 1'b1;
         end
      end
   endtask

   task automatic drive_write(input int x, input int y, input logic d, input logic fd);
      @(negedge clk);
      writeEnable    = 1'b1;
      xMedianAddress = 8'(x);
      yMedianAddress = 8'(y);
      dataIn         = d;
      filterDone     = fd;
      model_write(x, y, d);
   endtask

   task automatic drive_done();
      @(negedge clk);
      writeEnable = 1'b0;
      filterDone  = 1'b1;
   endtask

   task automatic start_frame();
      int k;
      @(negedge clk);
      start = 1'b1;
      model_start();
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      k = 0;
      while (!bufferReady && k < 7000) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("buffer_ready_latency", k, CLEAR_EN ? WORDS : 1);
   endtask

   // filterDone (with or without a write) is already driven; this covers edge M onward
   task automatic end_capture();
      int k;
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      filterDone  = 1'b0;
      for (int i = 0; i < WORDS; i++) exp_q.push_back(model_mem[i]);
      k = 0;
      while (!byteValid && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("drain_latency", k, 3);
   endtask

   task automatic drain(input bit bp, input int stop_at, input bit poke_start);
      int         cyc;
      logic       rdy, stalled, prev_last;
      logic [7:0] prev_dat, e;
      cyc = 0;
      stalled = 1'b0;
      prev_dat = 8'h00;
      prev_last = 1'b0;
      rx_cnt = 0;
      while (rx_cnt < stop_at && cyc < 40000) begin
         @(negedge clk);
         if (stalled) begin
            check("stall_hold_valid", byteValid, 1);
            check("stall_hold_data", byteOut, prev_dat);
            check("stall_hold_last", byteLast, prev_last);
         end
         rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         byteReady = rdy;
         start = poke_start && (cyc == 200);
         if (byteValid && rdy) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("drain_byte", byteOut, e);
            end
            check("byte_last", byteLast, (rx_cnt == WORDS - 1));
            if (rx_cnt < WORDS) rx[rx_cnt] = byteOut;
            rx_cnt++;
         end
         stalled   = byteValid && !rdy;
         prev_dat  = byteOut;
         prev_last = byteLast;
         cyc++;
      end
      start = 1'b0;
      check("drain_complete", rx_cnt, stop_at);
   endtask

   task automatic finish_frame();
      check("busy_before_last", busy, 1);
      @(posedge clk);
      #1;
      check("busy_fall", busy, 0);
      check("valid_after_last", byteValid, 0);
      byteReady = 1'b0;
      check("scoreboard_empty", exp_q.size(), 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{x: 8,   y: 0,   d: 1'b1, exp_oerr: 1'b0, exp_rerr: 1'b0};
      tbl[1] = '{x: 10,  y: 0,   d: 1'b1, exp_oerr: 1'b0, exp_rerr: 1'b0};
      tbl[2] = '{x: 9,   y: 0,   d: 1'b0, exp_oerr: 1'b0, exp_rerr: 1'b0};
      tbl[3] = '{x: 20,  y: 0,   d: 1'b1, exp_oerr: 1'b0, exp_rerr: 1'b0};
      tbl[4] = '{x: 3,   y: 0,   d: 1'b1, exp_oerr: 1'b1, exp_rerr: 1'b0};
      tbl[5] = '{x: 240, y: 0,   d: 1'b1, exp_oerr: 1'b1, exp_rerr: 1'b1};
      tbl[6] = '{x: 100, y: 2,   d: 1'b1, exp_oerr: 1'b1, exp_rerr: 1'b1};
      tbl[7] = '{x: 7,   y: 179, d: 1'b1, exp_oerr: 1'b1, exp_rerr: 1'b1};

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_buffer_ready", bufferReady, 0);
      check("rst_byte_valid", byteValid, 0);
      check("rst_byte_last", byteLast, 0);
      check("rst_byte_out", byteOut, 8'h00);
      check("rst_order_error", orderError, 0);
      check("rst_range_error", rangeError, 0);
      @(negedge clk);
      reset = 1'b0;

      // a wild write while IDLE must be ignored
      @(negedge clk);
      writeEnable = 1'b1;
      xMedianAddress = 8'd240;
      @(negedge clk);
      writeEnable = 1'b0;
      xMedianAddress = 8'd0;
      check("idle_write_no_range_error", rangeError, 0);
      check("idle_write_not_busy", busy, 0);

      // frame 1: establish a zero buffer, then reset in the middle of DRAIN
      start_frame();
      if (!CLEAR_EN) begin
         for (int w = 0; w < WORDS; w++) drive_write((w % 30) * 8, w / 30, 1'b0, 1'b0);
      end
      drive_done();
      end_capture();
      drain(1'b0, 10, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      byteReady = 1'b0;
      #1;
      check("reset_mid_drain_valid", byteValid, 0);
      check("reset_mid_drain_busy", busy, 0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;

      // frame 2: full filter-order interior of ones, no backpressure
      start_frame();
      for (int y = 1; y <= 178; y++) begin
         for (int x = 1; x <= 238; x++) drive_write(x, y, 1'b1, 1'b0);
      end
      drive_done();
      end_capture();
      drain(1'b0, WORDS, 1'b0);
      finish_frame();
      check("full_byte0", rx[0], 8'h00);
      check("full_byte30", rx[30], 8'hFE);
      check("full_byte59", rx[59], 8'h7F);
      check("full_byte5399", rx[5399], 8'h00);
      check("full_order_error", orderError, 0);
      check("full_range_error", rangeError, 0);

      // frame 3: packing, error table, coincident write+filterDone, backpressure, start in DRAIN
      start_frame();
      for (int i = 0; i < 8; i++) begin
         drive_write(tbl[i].x, tbl[i].y, tbl[i].d, 1'b0);
         @(posedge clk);
         #1;
         check("table_order_error", orderError, tbl[i].exp_oerr);
         check("table_range_error", rangeError, tbl[i].exp_rerr);
      end
      drive_write(239, 179, 1'b1, 1'b1);
      end_capture();
      drain(1'b1, WORDS, 1'b1);
      finish_frame();
      check("pack_byte0", rx[0], 8'h00);
      check("pack_byte1", rx[1], 8'h05);
      check("pack_byte2", rx[2], 8'h10);
      check("range_word30_unchanged", rx[30], CLEAR_EN ? 8'h00 : 8'hFE);
      check("touched_word72", rx[72], 8'h10);
      check("word5370", rx[5370], 8'h80);
      check("coincident_word5399", rx[5399], 8'h80);
      repeat (3) @(posedge clk);
      #1;
      check("start_in_drain_ignored", busy, 0);
      check("order_error_sticky", orderError, 1);
      check("range_error_sticky", rangeError, 1);

      // a new start clears the sticky flags on its own edge
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("start_clears_order_error", orderError, 0);
      check("start_clears_range_error", rangeError, 0);
      reset = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
